counter_cmd_sequencer: RTL and testbench
========================================

# counter_cmd_sequencer

Command-driven controller for the 4-bit load/increment/decrement/shift counter. It accepts queued commands over a valid/ready interface and drives the counter's `D`/`L`/`INC`/`DEC`/`SHL`/`SHR` inputs with correctly sequenced, mutually exclusive one-cycle strobes. It also keeps a shadow copy of the counter value, so upstream logic can read the expected counter state without a feedback path.

## Interface
- `W`, 4: counter data width.
- `DEPTH`, 4: command FIFO depth, power of two, at least 2.
- `RW`, 4: repeat-count field width.

- `C`  in  1: clock, rising edge.
- `RN`  in  1: asynchronous, active-low reset.
- `CMD_VALID`  in  1: command offered.
- `CMD_READY`  out  1: FIFO not full. Driven directly from the FIFO count and does not depend on a same-cycle pop.
- `CMD_OP`  in  3: opcode. 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6–7 illegal.
- `CMD_ARG`  in  W: load value, or the shift-in source bits.
- `CMD_REP`  in  RW: number of extra repetitions. The command is issued `CMD_REP`+1 times.
- `D`  out  W: data to the counter.
- `L`, `INC`, `DEC`, `SHL`, `SHR`  out  1 each: counter strobes. At most one is high in any cycle.
- `BUSY`  out  1: high while a command is issuing or the FIFO is non-empty.
- `SHADOW`  out  W: predicted counter value after all strobes issued so far.
- `ERR`  out  1: sticky. Set when an illegal opcode is accepted.

## Operation
- A handshake occurs when `CMD_VALID` and `CMD_READY` are both high at a rising edge of `C`. `{OP, ARG, REP}` is then pushed into the FIFO.
- Illegal opcodes are pushed normally. When popped, they set `ERR`, issue no strobes, and take one cycle.
- NOP behaves the same way but does not set `ERR`.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the command register, load the repeat counter with `REP`, and go to ISSUE.
  - ISSUE: assert the strobe selected by the opcode.
    - If the repeat counter is non-zero, decrement it.
    - At zero with the FIFO non-empty, pop the next command and stay in ISSUE. Back-to-back commands have no gap cycle.
    - At zero with the FIFO empty, return to IDLE.
- LOAD ignores `REP` and always issues exactly once.
- Strobes and `D` are registered outputs. `D` holds `ARG` for the whole command, so:
  - SHL shifts in `ARG[0]`;
  - SHR shifts in `ARG[W-1]`.
- Between commands and in IDLE, `D` keeps its last value and all strobes are 0.
- `SHADOW` updates on the same edge the strobe is registered. The rules are:
  - LOAD: `ARG`;
  - INC: +1, wrapping modulo 2^W (F→0 for `W`=4);
  - DEC: −1, wrapping (0→F);
  - SHL: `{SHADOW[W-2:0], ARG[0]}`;
  - SHR: `{ARG[W-1], SHADOW[W-1:1]}`.
- The counter itself has no reset, so `SHADOW` tracks it only after the first LOAD.
- `BUSY` = (state == ISSUE) or FIFO non-empty.

## Timing
- Reset (`RN` low) takes effect immediately, independent of `C`:
  - FIFO emptied, state IDLE, repeat counter 0;
  - `CMD_READY`=1 (FIFO empty), all strobes 0, `D`=0, `SHADOW`=0, `ERR`=0, `BUSY`=0.
- Reset mid-command drops the strobe immediately and discards both the queued commands and the remaining repeats.
- Latency: a command accepted at edge k with the block idle is popped at edge k+1. Its first strobe is high from edge k+2 to edge k+3, so the counter samples it at edge k+3.
- A command with repeat count `REP` occupies `REP`+1 consecutive strobe cycles (LOAD, NOP and illegal: 1).
- FIFO full: `CMD_READY`=0 and no push happens. A push and a pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.

## Structure
- Shared package holds:
  - the opcode constants (`OP_NOP` … `OP_SHR`);
  - the command struct `{op, arg, rep}`;
  - the FSM state encoding.
- Sub-module: `cmd_fifo`, a synchronous FIFO parameterised by `DEPTH` and payload width. It provides `full` and `empty` and a registered pop output, and uses the same asynchronous active-low reset.
- The top level contains the FSM, the repeat counter, the strobe/`D` registers and the `SHADOW` arithmetic.

## Test plan
- LOAD `ARG`=9, then INC `REP`=2 → `L` high for 1 cycle, then `INC` high for 3 consecutive cycles; `SHADOW` goes 9, A, B, C.
- LOAD 0, then DEC `REP`=0 → `SHADOW`=F (wrap). LOAD F, then INC → `SHADOW`=0.
- LOAD 0110, then SHL `ARG`=0001 twice → `SHADOW`=1101 then 1011. Then SHR `ARG`=1000 → 1101. `D` holds `ARG` for the duration of each command.
- Push 4 commands with `REP`=3 and the FIFO stalled → `CMD_READY`=0 after the 4th push. Strobes are back-to-back with no idle gap, and strobe activity lasts 16 cycles in total.
- Push opcode 7, then INC → `ERR`=1 and stays 1. The illegal command produces no strobe; the INC still issues.
- Assert `RN` low during the second cycle of an INC with `REP`=5 → strobe drops immediately, FIFO empties, `SHADOW`=0, `BUSY`=0. After release, `CMD_READY`=1.
- Every test checks on every cycle that at most one strobe is high, in particular never `INC` and `DEC` together.

Source files
------------

// File: rtl/counter_cmd_sequencer_pkg.sv
// rtl/counter_cmd_sequencer_pkg.sv - opcodes, command record and FSM encoding for the counter command sequencer
package counter_cmd_sequencer_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;

  // Command record at the default widths (W=4, RW=4); the FIFO payload uses the same field order.
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] arg;
    logic [3:0] rep;
  } cmd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Only the counting/shifting opcodes honour the repeat field.
  function automatic logic op_repeats(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/counter_cmd_sequencer_fifo.sv
// rtl/counter_cmd_sequencer_fifo.sv - synchronous command FIFO with registered pop output
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic [PW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/counter_cmd_sequencer.sv
// rtl/counter_cmd_sequencer.sv - queued command sequencer driving one-hot counter strobes and a shadow value
module counter_cmd_sequencer
  import counter_cmd_sequencer_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int RW    = 4
) (
  input  logic          C,
  input  logic          RN,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [2:0]    CMD_OP,
  input  logic [W-1:0]  CMD_ARG,
  input  logic [RW-1:0] CMD_REP,
  output logic [W-1:0]  D,
  output logic          L,
  output logic          INC,
  output logic          DEC,
  output logic          SHL,
  output logic          SHR,
  output logic          BUSY,
  output logic [W-1:0]  SHADOW,
  output logic          ERR
);

  localparam int PW = 3 + W + RW;

  state_t        state;
  logic          full;
  logic          empty;
  logic          pop;
  logic [PW-1:0] cur;
  logic [2:0]    cur_op;
  logic [W-1:0]  cur_arg;
  logic [RW-1:0] cur_rep;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] remaining;
  logic          first;

  cmd_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk       (C),
    .rst_n     (RN),
    .push      (CMD_VALID),
    .push_data ({CMD_OP, CMD_ARG, CMD_REP}),
    .pop       (pop),
    .pop_data  (cur),
    .full      (full),
    .empty     (empty)
  );

  assign cur_op  = cur[PW-1 -: 3];
  assign cur_arg = cur[RW +: W];
  assign cur_rep = cur[RW-1:0];

  // The repeat field only becomes visible once the registered pop lands, so the
  // first issue cycle takes it straight from the command register.
  assign remaining = first ? (op_repeats(cur_op) ? cur_rep : '0) : rep_cnt;

  assign pop       = !empty && ((state == ST_IDLE) || (remaining == '0));
  assign CMD_READY = !full;
  assign BUSY      = (state == ST_ISSUE) || !empty;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state   <= ST_IDLE;
      rep_cnt <= '0;
      first   <= 1'b0;
      L       <= 1'b0;
      INC     <= 1'b0;
      DEC     <= 1'b0;
      SHL     <= 1'b0;
      SHR     <= 1'b0;
      D       <= '0;
      SHADOW  <= '0;
      ERR     <= 1'b0;
    end else begin
      L   <= 1'b0;
      INC <= 1'b0;
      DEC <= 1'b0;
      SHL <= 1'b0;
      SHR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state   <= ST_ISSUE;
            first   <= 1'b1;
            rep_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          case (cur_op)
            OP_NOP: ;
            OP_LOAD: begin
              L      <= 1'b1;
              D      <= cur_arg;
              SHADOW <= cur_arg;
            end
            OP_INC: begin
              INC    <= 1'b1;
              D      <= cur_arg;
              SHADOW <= SHADOW + 1'b1;
            end
            OP_DEC: begin
              DEC    <= 1'b1;
              D      <= cur_arg;
              SHADOW <= SHADOW - 1'b1;
            end
            OP_SHL: begin
              SHL    <= 1'b1;
              D      <= cur_arg;
              SHADOW <= {SHADOW[W-2:0], cur_arg[0]};
            end
            OP_SHR: begin
              SHR    <= 1'b1;
              D      <= cur_arg;
              SHADOW <= {cur_arg[W-1], SHADOW[W-1:1]};
            end
            default: ERR <= 1'b1;
          endcase
          if (remaining != '0) begin
            rep_cnt <= remaining - 1'b1;
            first   <= 1'b0;
          end else if (!empty) begin
            first   <= 1'b1;
            rep_cnt <= '0;
          end else begin
            state   <= ST_IDLE;
            first   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb/tb_counter_cmd_sequencer.sv - scoreboard bench for counter_cmd_sequencer
module tb_counter_cmd_sequencer;
  import counter_cmd_sequencer_pkg::*;

  logic       C = 1'b0;
  logic       RN = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [2:0] CMD_OP = 3'd0;
  logic [3:0] CMD_ARG = 4'd0;
  logic [3:0] CMD_REP = 4'd0;
  logic [3:0] D;
  logic       L, INC, DEC, SHL, SHR;
  logic       BUSY;
  logic [3:0] SHADOW;
  logic       ERR;

  counter_cmd_sequencer #(.W(4), .DEPTH(4), .RW(4)) dut (
    .C(C), .RN(RN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ARG(CMD_ARG), .CMD_REP(CMD_REP),
    .D(D), .L(L), .INC(INC), .DEC(DEC), .SHL(SHL), .SHR(SHR),
    .BUSY(BUSY), .SHADOW(SHADOW), .ERR(ERR)
  );

  always #5 C = ~C;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] d;
    logic [3:0] shadow;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         strobe_cycles = 0;
  int         first_strobe = -1;
  int         last_strobe = -1;
  logic [3:0] model_shadow = 4'd0;

  always @(posedge C) cyc <= cyc + 1;

  // Monitor: every strobe cycle must match the next predicted strobe.
  always @(negedge C) begin
    int         n;
    logic [2:0] kind;
    exp_t       e;
    if (RN) begin
      n = int'(L) + int'(INC) + int'(DEC) + int'(SHL) + int'(SHR);
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL strobe_onehot cyc=%0d got L%b INC%b DEC%b SHL%b SHR%b required at most one", cyc, L, INC, DEC, SHL, SHR);
      end
      if (n == 1) begin
        kind = L ? OP_LOAD : INC ? OP_INC : DEC ? OP_DEC : SHL ? OP_SHL : OP_SHR;
        strobe_cycles++;
        if (first_strobe < 0) first_strobe = cyc;
        last_strobe = cyc;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got op %0d D=%h SHADOW=%h required no strobe", cyc, kind, D, SHADOW);
        end else begin
          e = sbq.pop_front();
          if (kind != e.kind || D != e.d || SHADOW != e.shadow) begin
            errors++;
            $display("FAIL strobe cyc=%0d got op %0d D=%h SHADOW=%h required op %0d D=%h SHADOW=%h",
                     cyc, kind, D, SHADOW, e.kind, e.d, e.shadow);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_strobes(input cmd_t c);
    int n;
    n = (c.op == OP_LOAD) ? 1 : (op_repeats(c.op) ? int'(c.rep) + 1 : 0);
    for (int i = 0; i < n; i++) begin
      case (c.op)
        OP_LOAD: model_shadow = c.arg;
        OP_INC:  model_shadow = model_shadow + 4'd1;
        OP_DEC:  model_shadow = model_shadow - 4'd1;
        OP_SHL:  model_shadow = {model_shadow[2:0], c.arg[0]};
        default: model_shadow = {c.arg[3], model_shadow[3:1]};
      endcase
      sbq.push_back('{kind: c.op, d: c.arg, shadow: model_shadow});
    end
  endtask

  // Returns #1 after the handshake edge.
  task automatic push(input cmd_t c);
    int t;
    CMD_OP = c.op;
    CMD_ARG = c.arg;
    CMD_REP = c.rep;
    CMD_VALID = 1'b1;
    t = 0;
    @(negedge C);
    while (!CMD_READY && t < 100) begin
      @(negedge C);
      t++;
    end
    if (!CMD_READY) begin
      errors++;
      $display("FAIL push_timeout got CMD_READY=0 required 1");
    end
    @(posedge C);
    #1;
    CMD_VALID = 1'b0;
    expect_strobes(c);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge C);
    while (BUSY && t < 200) begin
      @(negedge C);
      t++;
    end
    if (BUSY) begin
      errors++;
      $display("FAIL idle_timeout got BUSY=1 required 0");
    end
    @(posedge C);
    #1;
  endtask

  task automatic clear_counts();
    strobe_cycles = 0;
    first_strobe = -1;
    last_strobe = -1;
  endtask

  function automatic logic [4:0] strobes();
    return {L, INC, DEC, SHL, SHR};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge C);
    #1;
    check("rst_ready", CMD_READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_strobes", strobes(), 0);
    check("rst_d", D, 0);
    check("rst_shadow", SHADOW, 0);
    check("rst_err", ERR, 0);
    RN = 1'b1;
    @(posedge C);
    #1;

    // LOAD 9 then INC x3, including first-strobe latency
    clear_counts();
    push(cmd_t'{OP_LOAD, 4'h9, 4'h0});
    @(posedge C);
    #1;
    check("lat_k1_l", L, 0);
    check("lat_k1_busy", BUSY, 1);
    @(posedge C);
    #1;
    check("lat_k2_l", L, 1);
    check("lat_k2_d", D, 4'h9);
    push(cmd_t'{OP_INC, 4'h0, 4'h2});
    wait_idle();
    check("t1_shadow", SHADOW, 4'hC);
    check("t1_strobe_cycles", 8'(strobe_cycles), 4);
    check("t1_drained", 8'(sbq.size()), 0);

    // wrap both ways
    push(cmd_t'{OP_LOAD, 4'h0, 4'h0});
    push(cmd_t'{OP_DEC, 4'h0, 4'h0});
    wait_idle();
    check("dec_wrap", SHADOW, 4'hF);
    push(cmd_t'{OP_LOAD, 4'hF, 4'h0});
    push(cmd_t'{OP_INC, 4'h0, 4'h0});
    wait_idle();
    check("inc_wrap", SHADOW, 4'h0);

    // shifts
    push(cmd_t'{OP_LOAD, 4'b0110, 4'h0});
    push(cmd_t'{OP_SHL, 4'b0001, 4'h1});
    push(cmd_t'{OP_SHR, 4'b1000, 4'h0});
    wait_idle();
    check("shift_shadow", SHADOW, 4'b1101);
    check("shift_d_hold", D, 4'b1000);

    // burst: first command starts issuing, the next four fill the FIFO
    clear_counts();
    push(cmd_t'{OP_INC, 4'h0, 4'h3});
    push(cmd_t'{OP_DEC, 4'h0, 4'h3});
    push(cmd_t'{OP_SHL, 4'h5, 4'h3});
    push(cmd_t'{OP_SHR, 4'h2, 4'h3});
    push(cmd_t'{OP_INC, 4'h0, 4'h3});
    check("full_ready", CMD_READY, 0);
    wait_idle();
    check("burst_cycles", 8'(strobe_cycles), 20);
    check("burst_no_gap", 8'(last_strobe - first_strobe + 1), 20);
    check("burst_drained", 8'(sbq.size()), 0);

    // illegal opcode
    check("err_clear", ERR, 0);
    push(cmd_t'{3'd7, 4'h3, 4'h2});
    push(cmd_t'{OP_INC, 4'h0, 4'h0});
    wait_idle();
    check("err_set", ERR, 1);
    repeat (5) @(posedge C);
    #1;
    check("err_sticky", ERR, 1);
    check("err_drained", 8'(sbq.size()), 0);

    // reset during the second strobe of INC x6, with another command queued
    push(cmd_t'{OP_INC, 4'h0, 4'h5});
    push(cmd_t'{OP_DEC, 4'h0, 4'h0});
    @(posedge C);
    @(posedge C);
    #1;
    check("pre_rst_inc", INC, 1);
    RN = 1'b0;
    #1;
    check("mid_rst_strobes", strobes(), 0);
    check("mid_rst_shadow", SHADOW, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_d", D, 0);
    sbq.delete();
    model_shadow = 4'd0;
    @(posedge C);
    #1;
    RN = 1'b1;
    @(posedge C);
    #1;
    check("post_rst_ready", CMD_READY, 1);
    check("post_rst_busy", BUSY, 0);
    repeat (3) @(posedge C);
    #1;
    check("post_rst_quiet", strobes(), 0);
    push(cmd_t'{OP_LOAD, 4'h3, 4'h0});
    wait_idle();
    check("post_rst_load", SHADOW, 4'h3);
    check("final_drained", 8'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
